// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared constants and FSM state encoding for the binary
//                fully-connected layer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    // Layer geometry
    localparam int N_IN       = 784;
    localparam int N_OUT      = 256;
    localparam int THR_W      = 10;

    // Neuron index width, and counter width able to hold the terminal count N_OUT
    localparam int IDX_W      = $clog2(N_OUT);
    localparam int CNT_W      = IDX_W + 1;

    // Pipeline depth of the XNOR/popcount/threshold engine
    localparam int ENGINE_LAT = 4;

    // Window after reset during which stale engine results are discarded
    localparam int GUARD_W    = $clog2(ENGINE_LAT + 2);

    // Issue-interval down-counter width (interval is at most 15)
    localparam int TMR_W      = 4;

    // Controller states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fc_issue_timer.sv
`default_nettype none
// ============================================================================
//  Module      : fc_issue_timer
//  Description : Paces ROM reads / engine issues. After a start pulse it
//                strobes mem_rd_en for neuron 0 on the next cycle, then every
//                ISSUE_INTERVAL cycles for neurons 1..N_OUT-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_issue_timer
    import fc_pkg::*;
#(
    parameter int ISSUE_INTERVAL = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    output logic             last_issue
);

    logic             r_active;
    logic [TMR_W-1:0] r_wait;
    logic [CNT_W-1:0] r_idx;
    logic             w_fire;

    assign w_fire     = r_active && (r_wait == '0);
    assign mem_rd_en  = w_fire;
    assign mem_addr   = r_idx[IDX_W-1:0];
    assign last_issue = w_fire && (r_idx == CNT_W'(N_OUT - 1));

    // Issue index and inter-issue down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_wait   <= '0;
            r_idx    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_wait   <= '0;
            r_idx    <= '0;
        end else if (w_fire) begin
            r_idx  <= r_idx + 1'b1;
            r_wait <= TMR_W'(ISSUE_INTERVAL - 1);
            if (last_issue) begin
                r_active <= 1'b0;
            end
        end else if (r_active) begin
            r_wait <= r_wait - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fc_layer_ctrl
//  Description : Sequencer for the binary fully-connected neuron engine.
//                Latches one input vector, fetches each neuron's weight row
//                and threshold, issues it to the engine, and assembles the
//                N_OUT result bits into a vector handed downstream over a
//                valid/ready handshake.
//                Optional macro FC_LAYER_CTRL_PERF_EN adds o_cycles, a
//                saturating count of busy (RUN/DRAIN) cycles per layer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_ctrl
    import fc_pkg::*;
#(
    parameter int ISSUE_INTERVAL = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [N_IN-1:0]  i_data,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [N_IN-1:0]  mem_weight,
    input  logic [THR_W-1:0] mem_thr,
    output logic             eng_valid,
    output logic [N_IN-1:0]  eng_data,
    output logic [N_IN-1:0]  eng_weight,
    output logic [THR_W-1:0] eng_threshold,
    input  logic             eng_result,
    input  logic             eng_res_valid,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [N_OUT-1:0] o_result,
    output logic             o_err
`ifdef FC_LAYER_CTRL_PERF_EN
    ,
    output logic [15:0]      o_cycles
`endif
);

    // The engine reads its threshold from its input stage, so two issues on
    // adjacent cycles would hand one neuron the next neuron's threshold.
    if (ISSUE_INTERVAL < 2 || ISSUE_INTERVAL > 15) begin : g_bad_interval
        $error("fc_layer_ctrl: ISSUE_INTERVAL must be in 2..15");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_in_ready;
    logic               r_eng_valid;
    logic [N_IN-1:0]    r_eng_data;
    logic [N_OUT-1:0]   r_result;
    logic [CNT_W-1:0]   r_res_cnt;
    logic               r_err;
    logic [GUARD_W-1:0] r_guard;

    logic               w_accept;
    logic               w_last_issue;
    logic               w_collect;
    logic               w_res_evt;
    logic               w_res_take;
    logic               w_res_bad;

    assign w_accept  = i_valid && r_in_ready;
    assign w_collect = (r_state == c_st_run) || (r_state == c_st_drain);
    // Results arriving right after a reset belong to an abandoned layer
    assign w_res_evt  = eng_res_valid && (r_guard == '0);
    assign w_res_take = w_res_evt && w_collect && (r_res_cnt < CNT_W'(N_OUT));
    assign w_res_bad  = w_res_evt && !w_res_take;

    assign i_ready       = r_in_ready;
    assign eng_valid     = r_eng_valid;
    assign eng_data      = r_eng_data;
    assign eng_weight    = mem_weight;
    assign eng_threshold = mem_thr;
    assign o_valid       = (r_state == c_st_done);
    assign o_result      = r_result;
    assign o_err         = r_err;

    fc_issue_timer #(
        .ISSUE_INTERVAL (ISSUE_INTERVAL)
    ) u_issue_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (w_accept),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .last_issue (w_last_issue)
    );

    // State register and registered input-ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == c_st_idle);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_last_issue) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if ((w_res_take && (r_res_cnt == CNT_W'(N_OUT - 1))) ||
                    (r_res_cnt == CNT_W'(N_OUT))) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (o_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Input vector latch and engine issue strobe (one cycle after the ROM read)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eng_data  <= '0;
            r_eng_valid <= 1'b0;
        end else begin
            r_eng_valid <= mem_rd_en;
            if (w_accept) begin
                r_eng_data <= i_data;
            end
        end
    end

    // In-order result assembly; the vector is held between layers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_res_cnt <= '0;
        end else if (w_accept) begin
            r_res_cnt <= '0;
        end else if (w_res_take) begin
            r_result[r_res_cnt[IDX_W-1:0]] <= eng_result;
            r_res_cnt                      <= r_res_cnt + 1'b1;
        end
    end

    // Sticky error for results nobody asked for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_res_bad) begin
            r_err <= 1'b1;
        end
    end

    // Post-reset window covering results still in the engine pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guard <= GUARD_W'(ENGINE_LAT + 1);
        end else if (r_guard != '0) begin
            r_guard <= r_guard - 1'b1;
        end
    end

`ifdef FC_LAYER_CTRL_PERF_EN
    logic [15:0] r_cycles;

    assign o_cycles = r_cycles;

    // Busy-cycle counter, saturating, cleared when a new vector is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if (w_collect && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_layer_ctrl
//  Description : Self-checking bench for fc_layer_ctrl with ROM and engine
//                models and a vector-level reference of the layer function.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fc_layer_ctrl;

    localparam int NI  = 784;
    localparam int NO  = 256;
    localparam int TW  = 10;
    localparam int II  = 2;
    localparam int LAT = II * (NO - 1) + 7;   // accept cycle -> o_valid cycle
    localparam int BUSY = LAT - 1;            // cycles spent in RUN/DRAIN

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [NI-1:0] i_data = '0;
    logic          mem_rd_en;
    logic [7:0]    mem_addr;
    logic [NI-1:0] mem_weight = '0;
    logic [TW-1:0] mem_thr = '0;
    logic          eng_valid;
    logic [NI-1:0] eng_data;
    logic [NI-1:0] eng_weight;
    logic [TW-1:0] eng_threshold;
    logic          eng_result;
    logic          eng_res_valid;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [NO-1:0] o_result;
    logic          o_err;
`ifdef FC_LAYER_CTRL_PERF_EN
    logic [15:0]   o_cycles;
`endif

    fc_layer_ctrl #(.ISSUE_INTERVAL(II)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_data        (i_data),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_weight    (mem_weight),
        .mem_thr       (mem_thr),
        .eng_valid     (eng_valid),
        .eng_data      (eng_data),
        .eng_weight    (eng_weight),
        .eng_threshold (eng_threshold),
        .eng_result    (eng_result),
        .eng_res_valid (eng_res_valid),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_result      (o_result),
        .o_err         (o_err)
`ifdef FC_LAYER_CTRL_PERF_EN
        ,
        .o_cycles      (o_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents and models
    logic [NI-1:0] rom_w [NO];
    logic [TW-1:0] rom_t [NO];
    logic [3:0]    pipe_v = '0;
    logic [3:0]    pipe_r = '0;
    logic          spur_v = 1'b0;
    logic          spur_r = 1'b0;

    // ROM: data one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_weight <= rom_w[mem_addr];
            mem_thr    <= rom_t[mem_addr];
        end
    end

    // Engine: 4-cycle pipeline, not reset (in-flight results survive a reset)
    always @(posedge clk) begin
        pipe_v <= {pipe_v[2:0], eng_valid};
        pipe_r <= {pipe_r[2:0], eng_valid ?
                   ($countones(~(eng_data ^ eng_weight)) >= int'(eng_threshold)) : 1'b0};
    end

    assign eng_res_valid = pipe_v[3] | spur_v;
    assign eng_result    = spur_v ? spur_r : pipe_r[3];

    // Issue monitor
    int m_rd = 0, m_iss = 0, m_addr_err = 0, m_sp_err = 0, m_first = -1, m_last = 0;
    always @(negedge clk) begin
        if (rst || (i_valid && i_ready)) begin
            m_rd <= 0; m_iss <= 0; m_addr_err <= 0; m_sp_err <= 0; m_first <= -1;
        end else begin
            if (mem_rd_en) begin
                if (mem_addr !== 8'(m_rd)) m_addr_err <= m_addr_err + 1;
                if (m_rd == 0) m_first <= cyc;
                m_rd <= m_rd + 1;
            end
            if (eng_valid) begin
                if (m_iss > 0 && (cyc - m_last) != II) m_sp_err <= m_sp_err + 1;
                m_last <= cyc;
                m_iss  <= m_iss + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int t_acc = 0;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NI-1:0] rand_vec();
        logic [831:0] t;
        for (int i = 0; i < 26; i++) t[i*32 +: 32] = $urandom;
        return t[NI-1:0];
    endfunction

    // Layer function straight from the definition: bit k = matches(k) >= thr(k)
    function automatic logic [NO-1:0] ref_vec(input logic [NI-1:0] d);
        logic [NO-1:0] v;
        for (int k = 0; k < NO; k++)
            v[k] = ($countones(~(d ^ rom_w[k])) >= int'(rom_t[k]));
        return v;
    endfunction

    task automatic rand_rom();
        for (int k = 0; k < NO; k++) begin
            rom_w[k] = rand_vec();
            rom_t[k] = TW'($urandom_range(370, 414));
        end
    endtask

    task automatic start_layer(input logic [NI-1:0] d);
        int n;
        i_data  = d;
        i_valid = 1'b1;
        n = 0;
        while (i_ready !== 1'b1 && n < 50) begin step(); n++; end
        chk("accept_ready", i_ready, 1);
        t_acc = cyc;
        step();
        i_valid = 1'b0;
    endtask

    task automatic run_layer(input logic [NI-1:0] d, input logic exp_err, input string tag);
        logic [NO-1:0] exp_v;
        int n;
        exp_v = ref_vec(d);
        start_layer(d);
        n = 0;
        while (o_valid !== 1'b1 && n < 3000) begin step(); n++; end
        chk({tag, "_ovalid_timeout"}, o_valid, 1);
        chk({tag, "_latency"}, cyc - t_acc, LAT);
        chk({tag, "_result"}, o_result, exp_v);
        chk({tag, "_eng_issues"}, m_iss, NO);
        chk({tag, "_rd_count"}, m_rd, NO);
        chk({tag, "_addr_order_err"}, m_addr_err, 0);
        chk({tag, "_spacing_err"}, m_sp_err, 0);
        chk({tag, "_first_rd_ofs"}, m_first - t_acc, 1);
        chk({tag, "_o_err"}, o_err, exp_err);
`ifdef FC_LAYER_CTRL_PERF_EN
        chk({tag, "_cycles"}, o_cycles, BUSY);
`endif
    endtask

    task automatic release_result(input string tag);
        i_valid = 1'b0;
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        chk({tag, "_iready_after"}, i_ready, 1);
        chk({tag, "_ovalid_after"}, o_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NI-1:0] d, d2, m;
        logic [NO-1:0] v, saved;
        logic [NO-1:0] alt;
        logic          act;

        // ---- reset state ----
        step(); step();
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_o_result", o_result, 0);
        chk("rst_o_err", o_err, 0);
        chk("rst_eng_data", eng_data, 0);
        rst = 1'b0;
        step(); step();
        chk("idle_i_ready", i_ready, 1);

        // ---- known layer: even rows all ones, odd rows all zeros ----
        for (int k = 0; k < NO; k++) begin
            rom_w[k] = (k % 2 == 0) ? {NI{1'b1}} : {NI{1'b0}};
            rom_t[k] = TW'(392);
        end
        run_layer({NI{1'b1}}, 1'b0, "known");
        alt = {128{2'b01}};
        chk("known_const", o_result, alt);
        release_result("known");

        // ---- threshold boundary between neighbours ----
        rand_rom();
        d = rand_vec();
        m = '0;
        for (int i = 0; i < 392; i++) m[i] = 1'b1;
        rom_w[0] = d ^ m;                 // 392 matching bits
        m[392] = 1'b1;
        rom_w[1] = d ^ m;                 // 391 matching bits
        rom_t[0] = TW'(392);
        rom_t[1] = TW'(392);
        rom_t[2] = TW'(300);
        run_layer(d, 1'b0, "bound");
        chk("bound_bit0", o_result[0], 1);
        chk("bound_bit1", o_result[1], 0);
        release_result("bound");

        // ---- backpressure ----
        rand_rom();
        d = rand_vec();
        run_layer(d, 1'b0, "bp");
        saved = o_result;
        d2 = ~d;
        for (int i = 0; i < 50; i++) begin
            i_valid = 1'b1;
            i_data  = d2;
            step();
            chk("bp_result_stable", o_result, saved);
            chk("bp_i_ready", i_ready, 0);
            chk("bp_o_valid", o_valid, 1);
            chk("bp_eng_data", eng_data, d);
        end
        release_result("bp");
        rand_rom();
        run_layer(rand_vec(), 1'b0, "bp2");
        release_result("bp2");

        // ---- mid-layer reset ----
        rand_rom();
        start_layer(rand_vec());
        while (cyc < t_acc + 200) step();
        rst = 1'b1;
        #1;
        chk("mrst_o_valid", o_valid, 0);
        chk("mrst_mem_rd_en", mem_rd_en, 0);
        chk("mrst_eng_valid", eng_valid, 0);
        chk("mrst_o_result", o_result, 0);
        chk("mrst_o_err", o_err, 0);
        chk("mrst_eng_data", eng_data, 0);
        step();
        rst = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            act = act | mem_rd_en | eng_valid | o_valid | o_err;
        end
        chk("mrst_quiet_after", act, 0);
        chk("mrst_o_err_after", o_err, 0);
        rand_rom();
        run_layer(rand_vec(), 1'b0, "post_rst");
        release_result("post_rst");

        // ---- spurious result in IDLE ----
        saved  = o_result;
        spur_r = ~saved[0];
        spur_v = 1'b1;
        step();
        spur_v = 1'b0;
        step();
        chk("spur_o_err", o_err, 1);
        chk("spur_result_kept", o_result, saved);
        repeat (10) step();
        chk("spur_o_err_sticky", o_err, 1);
        rand_rom();
        run_layer(rand_vec(), 1'b1, "spur_layer");
        release_result("spur_layer");
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("spur_o_err_cleared", o_err, 0);
        chk("spur_rst_result", o_result, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
